// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe board controller.
// The win-line table is only consumed when WIN_DETECT_EN is defined.
package ttt_pkg;

  localparam int N_CELLS = 9;
  localparam int N_LINES = 8;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_FULL = 2'd1,
    ST_WON  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  // Entry 0 is the top row; then rows, columns, diagonals.
  localparam logic [N_LINES-1:0][2:0][3:0] WIN_LINES = {
    {4'd2, 4'd4, 4'd6}, {4'd0, 4'd4, 4'd8},
    {4'd2, 4'd5, 4'd8}, {4'd1, 4'd4, 4'd7}, {4'd0, 4'd3, 4'd6},
    {4'd6, 4'd7, 4'd8}, {4'd3, 4'd4, 4'd5}, {4'd0, 4'd1, 4'd2}
  };

  function automatic logic [N_CELLS-1:0] line_mask(input int l);
    logic [N_CELLS-1:0] m;
    m = '0;
    for (int k = 0; k < 3; k++) m[WIN_LINES[l][k]] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ttt_debounce.sv
// Per-cell switch conditioning: 2-flop synchroniser, stability counter,
// debounced level and a registered one-cycle pulse on its rising edge.
module ttt_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q, s2_q, deb_q, prev_q, rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      deb_q  <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= sw_i;
      s2_q   <= s1_q;
      prev_q <= deb_q;
      rise_q <= deb_q & ~prev_q;
      // Any return to agreement restarts the stability count.
      if (s2_q != deb_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/ttt_board_ctrl.sv
// Board controller: debounced cell presses become moves on a registered board.
// Define WIN_DETECT_EN to add line checking, the WON state and the winner output.
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic [N_CELLS-1:0] cell_sw_i,
  input  logic               p2_turn_i,
  output logic [N_CELLS-1:0] occupied_o,
  output logic [N_CELLS-1:0] owner_o,
  output logic [3:0]         move_count_o,
  output logic               move_valid_o,
  output logic [3:0]         move_idx_o,
  output logic               illegal_move_o,
  output logic               game_full_o,
  output logic [1:0]         winner_o
);

  logic [N_CELLS-1:0] req, free, pick;
  logic [3:0]         pick_idx;

  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
    ttt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_i   (cell_sw_i[gi]),
      .rise_o (req[gi])
    );
  end

  state_e             state_q, state_d;
  logic [N_CELLS-1:0] occ_q, occ_d, own_q, own_d;
  logic [3:0]         cnt_q, cnt_d, idx_q, idx_d;
  logic               vld_q, vld_d, ill_q, ill_d, full_q, full_d;
  logic               win_now;

  assign free = req & ~occ_q;
  assign pick = free & (~free + 1'b1);

  always_comb begin
    pick_idx = '0;
    for (int i = N_CELLS - 1; i >= 0; i--) if (free[i]) pick_idx = 4'(i);
  end

`ifdef WIN_DETECT_EN
  winner_e win_q, win_d, win_code;
  logic    chk_q, chk_d;

  // Lines are evaluated on the board registered by the previous accept.
  always_comb begin
    win_code = WIN_NONE;
    for (int l = 0; l < N_LINES; l++) begin
      if ((occ_q & line_mask(l)) == line_mask(l)) begin
        if ((own_q & line_mask(l)) == line_mask(l)) win_code = WIN_P2;
        else if ((own_q & line_mask(l)) == '0)      win_code = WIN_P1;
      end
    end
    win_now = chk_q && (win_code != WIN_NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= WIN_NONE;
      chk_q <= 1'b0;
    end else begin
      win_q <= win_d;
      chk_q <= chk_d;
    end
  end

  assign winner_o = win_q;
`else
  assign win_now  = 1'b0;
  assign winner_o = 2'b00;
`endif

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    vld_d   = 1'b0;
    ill_d   = 1'b0;
    idx_d   = '0;
`ifdef WIN_DETECT_EN
    win_d   = win_q;
    chk_d   = 1'b0;
`endif
    if (clear_i) begin
      state_d = ST_PLAY;
      occ_d   = '0;
      own_d   = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
`ifdef WIN_DETECT_EN
      win_d   = WIN_NONE;
`endif
    end else begin
`ifdef WIN_DETECT_EN
      if (win_now) begin
        win_d   = win_code;
        state_d = ST_WON;
      end
`endif
      if (|req) begin
        if (state_q == ST_PLAY && !win_now && |free) begin
          occ_d = occ_q | pick;
          own_d = p2_turn_i ? (own_q | pick) : own_q;
          cnt_d = cnt_q + 4'd1;
          vld_d = 1'b1;
          idx_d = pick_idx;
          ill_d = |(req & ~pick);
`ifdef WIN_DETECT_EN
          chk_d = 1'b1;
`endif
          if (cnt_q == 4'(N_CELLS - 1)) begin
            full_d  = 1'b1;
            state_d = ST_FULL;
          end
        end else begin
          ill_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PLAY;
      occ_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      ill_q   <= ill_d;
      full_q  <= full_d;
    end
  end

  assign occupied_o     = occ_q;
  assign owner_o        = own_q;
  assign move_count_o   = cnt_q;
  assign move_valid_o   = vld_q;
  assign move_idx_o     = idx_q;
  assign illegal_move_o = ill_q;
  assign game_full_o    = full_q;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Bench for ttt_board_ctrl: directed game scenarios plus random switch activity,
// scored every cycle against a press-timing and board-rules reference model.
module tb_ttt_board_ctrl;

  localparam int DC     = 4;
  localparam int LAT    = DC + 4;  // input changed after edge e is accepted at edge e+LAT
  localparam int SETTLE = DC + 3;
`ifdef WIN_DETECT_EN
  localparam int WIN_EN = 1;
`else
  localparam int WIN_EN = 0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, clear_i = 1'b0, p2_turn_i = 1'b0;
  logic [8:0] cell_sw_i = '0;
  logic [8:0] occupied_o, owner_o;
  logic [3:0] move_count_o, move_idx_o;
  logic       move_valid_o, illegal_move_o, game_full_o;
  logic [1:0] winner_o;

  ttt_board_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .cell_sw_i(cell_sw_i),
    .p2_turn_i(p2_turn_i), .occupied_o(occupied_o), .owner_o(owner_o),
    .move_count_o(move_count_o), .move_valid_o(move_valid_o),
    .move_idx_o(move_idx_o), .illegal_move_o(illegal_move_o),
    .game_full_o(game_full_o), .winner_o(winner_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, e = 0;
  bit m_occ[9], m_own[9];
  int m_cnt, m_win;
  bit m_full, m_won, m_pend, x_vld, x_ill, rnd_p2;
  int x_idx;
  int req_at[9], last_chg[9], gl_end[9];
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, e, got, exp);
    end
  endtask

  function automatic int vec(input bit b[9]);
    int v = 0;
    for (int i = 0; i < 9; i++) if (b[i]) v += (1 << i);
    return v;
  endfunction

  task automatic board_clear();
    for (int i = 0; i < 9; i++) begin m_occ[i] = 0; m_own[i] = 0; end
    m_cnt = 0; m_full = 0; m_won = 0; m_win = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    bit r[9];
    bit any;
    int pick;
    any = 0; pick = -1;
    x_vld = 0; x_ill = 0; x_idx = 0;
    if (!rst_n) begin
      board_clear();
      for (int i = 0; i < 9; i++) req_at[i] = -1;
      return;
    end
    for (int i = 0; i < 9; i++) begin
      r[i] = (req_at[i] == e);
      if (r[i]) begin any = 1; req_at[i] = -1; end
    end
    if (clear_i) begin board_clear(); return; end
    if (WIN_EN == 1 && m_pend) begin
      m_pend = 0;
      foreach (lines[l]) begin
        if (m_occ[lines[l][0]] && m_occ[lines[l][1]] && m_occ[lines[l][2]]) begin
          int n2 = m_own[lines[l][0]] + m_own[lines[l][1]] + m_own[lines[l][2]];
          if (n2 == 3) begin m_win = 2; m_won = 1; end
          else if (n2 == 0) begin m_win = 1; m_won = 1; end
        end
      end
    end
    if (any) begin
      if (m_full || m_won) x_ill = 1;
      else begin
        for (int i = 0; i < 9; i++) if (r[i] && !m_occ[i] && pick < 0) pick = i;
        for (int i = 0; i < 9; i++) if (r[i] && i != pick) x_ill = 1;
        if (pick >= 0) begin
          m_occ[pick] = 1; m_own[pick] = p2_turn_i; m_cnt++;
          x_vld = 1; x_idx = pick; m_pend = 1;
          if (m_cnt == 9) m_full = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("occupied", occupied_o, vec(m_occ));
    check("owner", owner_o, vec(m_own));
    check("move_count", move_count_o, m_cnt);
    check("move_valid", move_valid_o, x_vld);
    check("illegal_move", illegal_move_o, x_ill);
    check("game_full", game_full_o, m_full);
    check("winner", winner_o, m_win);
    if (x_vld) check("move_idx", move_idx_o, x_idx);
  endtask

  task automatic step();
    @(posedge clk); e++; #1;
    model_edge();
    check_all();
    p2_turn_i = rnd_p2 ? 1'($urandom_range(0, 1)) : 1'(m_cnt % 2);
  endtask

  function automatic bit settled(input int i);
    return (e - last_chg[i] >= SETTLE) && (gl_end[i] < 0);
  endfunction

  task automatic wait_settle();
    for (int k = 0; k < 200; k++) begin
      bit all_ok = 1;
      for (int i = 0; i < 9; i++) if (!settled(i)) all_ok = 0;
      if (all_ok) break;
      step();
    end
  endtask

  task automatic press(input int i);
    cell_sw_i[i] = 1'b1; last_chg[i] = e; req_at[i] = e + LAT;
  endtask

  task automatic release_sw(input int i);
    cell_sw_i[i] = 1'b0; last_chg[i] = e;
  endtask

  task automatic toggle(input int i);
    wait_settle();
    if (cell_sw_i[i]) begin release_sw(i); wait_settle(); end
    press(i); wait_settle();
    release_sw(i); wait_settle();
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1; step(); clear_i = 1'b0;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      last_chg[i] = e; gl_end[i] = -1;
      req_at[i] = cell_sw_i[i] ? e + LAT : -1;
    end
  endtask

  task automatic wait_move(input string tag, input int e0);
    for (int k = 0; k < LAT + 6 && !move_valid_o; k++) step();
    check(tag, e - e0, LAT);
  endtask

  initial begin
    int e0;
    board_clear();
    for (int i = 0; i < 9; i++) begin req_at[i] = -1; last_chg[i] = 0; gl_end[i] = -1; end
    rnd_p2 = 0;

    // Reset state
    repeat (3) step();
    release_reset();
    wait_settle();

    // First move on cell 4 with exact latency; short glitch on cell 0 is ignored
    e0 = e; press(4);
    wait_move("latency_c4", e0);
    wait_settle();
    cell_sw_i[0] = 1'b1; last_chg[0] = e;
    repeat (2) step();
    release_sw(0);
    wait_settle();

    // Re-press of a taken cell, then simultaneous presses on 2 and 7
    toggle(4);
    press(2); press(7); wait_settle();
    release_sw(2); release_sw(7); wait_settle();

    // Fill the board, extra press, clear with a switch still held
    for (int i = 0; i < 9; i++) toggle(i);
    toggle(5);
    press(0); wait_settle();
    pulse_clear();
    repeat (12) step();
    toggle(0);

    // Line 0,1,2 for P1 against 3,4 for P2, then cell 8
    pulse_clear();
    toggle(0); toggle(3); toggle(1); toggle(4); toggle(2);
    toggle(8);
    check("win_seq_winner", winner_o, WIN_EN);
    check("win_seq_cell8", occupied_o[8], 1 - WIN_EN);

    // Random switch activity, random turn input and occasional clears
    pulse_clear();
    rnd_p2 = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 9; i++) begin
        if (gl_end[i] == e) begin
          cell_sw_i[i] = 1'b0; last_chg[i] = e; gl_end[i] = -1;
        end else if (settled(i)) begin
          int r = $urandom_range(0, 99);
          if (!cell_sw_i[i]) begin
            if (r < 3) press(i);
            else if (r == 3) begin
              cell_sw_i[i] = 1'b1; last_chg[i] = e;
              gl_end[i] = e + $urandom_range(1, DC - 1);
            end
          end else if (r < 6) release_sw(i);
        end
      end
      clear_i = ($urandom_range(0, 99) < 2);
      step();
    end
    clear_i = 1'b0;
    rnd_p2 = 0;

    // Asynchronous reset mid-game and mid-debounce
    wait_settle();
    for (int i = 0; i < 9; i++) if (cell_sw_i[i]) release_sw(i);
    wait_settle();
    pulse_clear();
    toggle(1);
    press(5);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    board_clear();
    for (int i = 0; i < 9; i++) req_at[i] = -1;
    x_vld = 0; x_ill = 0;
    check_all();
    repeat (2) step();
    e0 = e;
    release_reset();
    wait_move("latency_post_reset", e0);
    wait_settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
